axi_lite_master_bridge: RTL and testbench
=========================================

Name: axi_lite_master_bridge

Overview:
- AXI-Lite initiator that converts a simple single-request valid/ready bus into AXI-Lite read and write transactions.
- It is the master-side counterpart of the CPU's AXI-Lite control/memory slave. A host-side sequencer or debug engine uses it to load instruction/data memory, write CPU control and PC, and poll status.
- One transaction is outstanding at a time.
- A per-transaction watchdog reports hung slaves instead of deadlocking.

Parameters:
ADDR_WIDTH, 32, width of req_addr and M_AXI_AWADDR/ARADDR
TIMEOUT_CYCLES, 1024, cycles from request accept to abort; 0 disables the watchdog
TO_WIDTH, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  write data
req_wstrb  in  4  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by the watchdog
busy  out  1  state != IDLE
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response code
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response code
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - All *VALID, BREADY, RREADY, rsp_valid, rsp_timeout, busy = 0.
  - All address/data/resp outputs = 0.
  - req_ready = 1 once reset is released.
  - Reset mid-transaction drops all valids at once; no response is produced.
- req_ready = (state==IDLE), combinational. A request is accepted on req_valid && req_ready, and all request fields are registered at that edge.
- State machine: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - Accepting a write moves to WRITE, with AWVALID=WVALID=1 from the next cycle.
  - Accepting a read moves to READ, with ARVALID=1 from the next cycle.
- WRITE:
  - aw_done and w_done are tracked independently.
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY.
  - Both handshakes may occur in the same cycle or in any order.
  - When both are done, go to WRESP with BREADY=1.
- WRESP: on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, BREADY=0, go to RESP.
- READ: on ARVALID&&ARREADY, ARVALID=0 and RREADY=1, go to RDATA.
- RDATA: on RVALID&&RREADY, capture RDATA/RRESP, RREADY=0, go to RESP.
- RESP:
  - rsp_valid=1; data is held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - A new request cannot be accepted in that same cycle; req_ready rises on the next cycle.
- Valid stability: AWADDR/WDATA/WSTRB/ARADDR and the *VALID signals never change while VALID is high and READY is low, except on watchdog abort or reset.
- Watchdog:
  - The counter clears on request accept and increments every cycle in WRITE/WRESP/READ/RDATA.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), all *VALID/BREADY/RREADY are forced to 0, rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and the state goes to RESP.
  - Timeout has priority over a completing handshake in the same cycle.
  - rsp_timeout clears when the response is consumed.
- Stray responses: BVALID/RVALID arriving outside WRESP/RDATA are ignored, because BREADY/RREADY are low.
- Throughput: minimum write = request accept + 1 AW/W cycle + 1 B cycle + 1 RESP cycle against a zero-wait slave. Reads follow the same pattern with AR and R.

Test Plan:
- Write 0x0000_0008, data 0x0000_0100, wstrb 4'hF, slave with 1-cycle AW/W ready and BRESP=00 -> one AW and one W handshake carrying those values; rsp_valid with rsp_resp=00, rsp_timeout=0, rsp_rdata=0; busy low afterwards.
- Read 0x0000_0004, slave returns RDATA=0x5249_5343, RRESP=00 -> ARADDR=0x04 for exactly one handshake; rsp_rdata=0x5249_5343.
- Write where WREADY arrives 5 cycles before AWREADY -> WVALID drops after its handshake while AWVALID is held; exactly one B handshake; AWADDR stable throughout.
- Read with RVALID held high and rsp_ready held low for 10 cycles -> rsp_valid, rsp_rdata and rsp_resp are stable; req_ready=0; a second req_valid is not accepted.
- TIMEOUT_CYCLES=16, slave never raises ARREADY -> ARVALID drops after 16 cycles; rsp_timeout=1, rsp_resp=10; the next read completes normally.
- Assert M_AXI_ARESET asynchronously mid-WRESP -> BREADY, AWVALID, WVALID and rsp_valid are 0 immediately; req_ready=1 after release; no response is produced.

Source files
------------

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: turns single host requests into AXI-Lite read/write
// transactions, one outstanding at a time, with a watchdog that aborts a
// transaction if the slave stops responding.
//
// Handshakes: every channel here (host req/rsp and AXI AW/W/B/AR/R) transfers
// on a rising clock edge where valid && ready are both high. Once a valid is
// raised, it and its payload stay unchanged until that transfer, unless the
// watchdog aborts or reset is asserted. Valid never waits on ready.
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 16
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  // host request / response
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [2:0]            state_dbg,
  // AXI-Lite write channels
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  // AXI-Lite read channels
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  // Counter value at which the next active cycle completes TIMEOUT_CYCLES.
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state;
  logic                aw_done;
  logic                w_done;
  logic [TO_WIDTH-1:0] wd_cnt;

  logic aw_fire;
  logic w_fire;
  logic aw_done_n;
  logic w_done_n;
  logic timeout_hit;

  // Channel completion flags for the independent AW and W handshakes.
  assign aw_fire   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire    = M_AXI_WVALID && M_AXI_WREADY;
  assign aw_done_n = aw_done || aw_fire;
  assign w_done_n  = w_done || w_fire;

  // Watchdog fires on the cycle that would make the active time reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == TO_LAST);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Transaction sequencer: all AXI and response outputs are registered here.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wd_cnt        <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wd_cnt <= '0;
            if (req_we) begin
              M_AXI_AWADDR  <= req_addr;
              M_AXI_WDATA   <= req_wdata;
              M_AXI_WSTRB   <= req_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WRITE;
            end else begin
              M_AXI_ARADDR  <= req_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= READ;
            end
          end
        end

        WRITE, WRESP, READ, RDATA: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (timeout_hit) begin
            // Abort wins over any handshake completing in this same cycle.
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_timeout   <= 1'b1;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (state == WRITE) begin
            if (aw_fire) M_AXI_AWVALID <= 1'b0;
            if (w_fire)  M_AXI_WVALID  <= 1'b0;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (aw_done_n && w_done_n) begin
              M_AXI_BREADY <= 1'b1;
              state        <= WRESP;
            end
          end else if (state == WRESP) begin
            if (M_AXI_BVALID) begin
              M_AXI_BREADY <= 1'b0;
              rsp_resp     <= M_AXI_BRESP;
              rsp_rdata    <= '0;
              rsp_timeout  <= 1'b0;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end
          end else if (state == READ) begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              state         <= RDATA;
            end
          end else begin
            if (M_AXI_RVALID) begin
              M_AXI_RREADY <= 1'b0;
              rsp_rdata    <= M_AXI_RDATA;
              rsp_resp     <= M_AXI_RRESP;
              rsp_timeout  <= 1'b0;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a task-driven AXI-Lite slave
// and a negedge monitor that counts handshakes and watches payload stability.
module tb_axi_lite_master_bridge;

  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    state_dbg;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  axi_lite_master_bridge #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .TO_WIDTH(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .state_dbg(state_dbg),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, ar_cycles = 0, stab_err = 0;
  logic [AW-1:0] aw_addr_seen, ar_addr_seen;
  logic [31:0]   w_data_seen;
  logic [3:0]    w_strb_seen;
  logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [31:0]   p_wdata;
  logic [3:0]    p_wstrb;

  always @(negedge clk) begin
    if (awvalid && awready) begin aw_hs++; aw_addr_seen = awaddr; end
    if (wvalid && wready) begin w_hs++; w_data_seen = wdata; w_strb_seen = wstrb; end
    if (bvalid && bready) b_hs++;
    if (arvalid && arready) begin ar_hs++; ar_addr_seen = araddr; end
    if (rvalid && rready) r_hs++;
    if (arvalid) ar_cycles++;
    if (!rst && !rsp_timeout) begin
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) stab_err++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) stab_err++;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) stab_err++;
    end
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr;
  end

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  task automatic issue_req(input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    check_eq("req_ready_before_req", req_ready, 1'b1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic run_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic [1:0] br, output bit ok);
    int cyc;
    issue_req(1'b1, addr, data, strb);
    cyc = 0; ok = 0;
    while (!ok && cyc < 64) begin
      awready = (cyc >= aw_dly); wready = (cyc >= w_dly); bvalid = 1; bresp = br;
      @(posedge clk); #1;
      cyc++; ok = rsp_valid;
    end
    slave_idle();
  endtask

  task automatic run_read(input logic [AW-1:0] addr, input bit ar_en, input int ar_dly,
                          input logic [31:0] rd, input logic [1:0] rr, output bit ok);
    int cyc;
    issue_req(1'b0, addr, 32'h0, 4'h0);
    cyc = 0; ok = 0;
    while (!ok && cyc < 64) begin
      arready = ar_en && (cyc >= ar_dly); rvalid = 1; rdata = rd; rresp = rr;
      @(posedge clk); #1;
      cyc++; ok = rsp_valid;
    end
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check_eq("rsp_valid_after_consume", rsp_valid, 1'b0);
    check_eq("req_ready_after_consume", req_ready, 1'b1);
    check_eq("busy_after_consume", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int b0, b1, b2, b3, b4, b5;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0;
    slave_idle();
    #2;
    check_eq("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check_eq("rst_rsp", {rsp_valid, rsp_timeout, busy}, 3'b0);
    check_eq("rst_data", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    check_eq("req_ready_after_reset", req_ready, 1'b1);

    // 1: basic write, zero-wait slave
    b0 = aw_hs; b1 = w_hs; b2 = b_hs;
    run_write(32'h0000_0008, 32'h0000_0100, 4'hF, 0, 0, 2'b00, ok);
    check_eq("w1_done", ok, 1'b1);
    check_eq("w1_resp", {rsp_timeout, rsp_resp}, 3'b000);
    check_eq("w1_rdata", rsp_rdata, 32'h0);
    check_eq("w1_aw_hs", aw_hs - b0, 1);
    check_eq("w1_w_hs", w_hs - b1, 1);
    check_eq("w1_b_hs", b_hs - b2, 1);
    check_eq("w1_awaddr", aw_addr_seen, 32'h8);
    check_eq("w1_wdata", {w_data_seen, w_strb_seen}, {32'h100, 4'hF});
    consume();

    // 2: basic read
    b3 = ar_hs; b4 = r_hs;
    run_read(32'h0000_0004, 1'b1, 0, 32'h5249_5343, 2'b00, ok);
    slave_idle();
    check_eq("r1_done", ok, 1'b1);
    check_eq("r1_rdata", rsp_rdata, 32'h5249_5343);
    check_eq("r1_resp", {rsp_timeout, rsp_resp}, 3'b000);
    check_eq("r1_ar_hs", ar_hs - b3, 1);
    check_eq("r1_r_hs", r_hs - b4, 1);
    check_eq("r1_araddr", ar_addr_seen, 32'h4);
    consume();

    // 3: W accepted five cycles before AW, slave returns SLVERR
    b0 = aw_hs; b1 = w_hs; b2 = b_hs;
    run_write(32'h0000_0010, 32'hA5A5_0F0F, 4'h3, 5, 0, 2'b10, ok);
    check_eq("w2_done", ok, 1'b1);
    check_eq("w2_aw_hs", aw_hs - b0, 1);
    check_eq("w2_w_hs", w_hs - b1, 1);
    check_eq("w2_b_hs", b_hs - b2, 1);
    check_eq("w2_awaddr", aw_addr_seen, 32'h10);
    check_eq("w2_wdata", {w_data_seen, w_strb_seen}, {32'hA5A5_0F0F, 4'h3});
    check_eq("w2_resp", {rsp_timeout, rsp_resp}, 3'b010);
    check_eq("w2_stability", stab_err, 0);
    consume();

    // 4: response held while consumer stalls; a second request must wait
    b3 = ar_hs;
    run_read(32'h0000_0020, 1'b1, 2, 32'hCAFE_F00D, 2'b01, ok);
    check_eq("r2_done", ok, 1'b1);
    req_valid = 1; req_we = 0; req_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      check_eq("r2_hold", {rsp_valid, req_ready, rsp_resp, rsp_rdata},
               {1'b1, 1'b0, 2'b01, 32'hCAFE_F00D});
      @(posedge clk); #1;
    end
    req_valid = 0;
    check_eq("r2_ar_hs", ar_hs - b3, 1);
    check_eq("r2_araddr", ar_addr_seen, 32'h20);
    slave_idle();
    consume();

    // 5: slave never accepts AR, watchdog aborts after 16 cycles
    b3 = ar_hs; b5 = ar_cycles;
    run_read(32'h0000_0030, 1'b0, 0, 32'h1111_2222, 2'b00, ok);
    slave_idle();
    check_eq("to_done", ok, 1'b1);
    check_eq("to_flags", {rsp_timeout, rsp_resp}, 3'b110);
    check_eq("to_rdata", rsp_rdata, 32'h0);
    check_eq("to_arvalid_cycles", ar_cycles - b5, 16);
    check_eq("to_ar_hs", ar_hs - b3, 0);
    check_eq("to_arvalid_low", arvalid, 1'b0);
    consume();
    check_eq("to_cleared", rsp_timeout, 1'b0);
    b3 = ar_hs;
    run_read(32'h0000_0004, 1'b1, 1, 32'h5249_5343, 2'b00, ok);
    slave_idle();
    check_eq("post_to_read", {ok, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h5249_5343});
    check_eq("post_to_ar_hs", ar_hs - b3, 1);
    consume();

    // 6: asynchronous reset while waiting for B
    b2 = b_hs;
    issue_req(1'b1, 32'h0000_0050, 32'h1234_5678, 4'hF);
    awready = 1; wready = 1;
    @(posedge clk); #1;
    awready = 0; wready = 0;
    check_eq("rst_mid_in_wresp", {state_dbg, bready}, {3'd2, 1'b1});
    #3 rst = 1;
    #1;
    check_eq("rst_mid_outputs", {bready, awvalid, wvalid, rsp_valid, busy}, 5'b0);
    @(posedge clk); #1;
    rst = 0;
    bvalid = 1; bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_req_ready", req_ready, 1'b1);
    check_eq("rst_mid_no_rsp", rsp_valid, 1'b0);
    check_eq("rst_mid_no_b_hs", b_hs - b2, 0);
    slave_idle();

    check_eq("valid_stability", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
